// File: rtl/shift_pkg.sv
// Shared types and line-level constants for the serial word assembler.
package shift_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2,
      ST_STOP   = 2'd3
   } state_t;

   localparam logic START_BIT = 1'b1;
   localparam logic STOP_BIT  = 1'b0;
   localparam logic IDLE_LVL  = 1'b0;

   // Even parity over data plus parity bit; nonzero means the frame is corrupt.
   function automatic logic par_fail(input logic [15:0] bits, input logic par_bit);
      return (^bits) ^ par_bit;
   endfunction

endpackage

// File: rtl/word_out_buf.sv
// Single-entry output holding register with valid/ready handshake and error flags.
// Latency: a good frame appears on data/valid the same edge it is written.
// Backpressure: a word arriving while full and not being read is dropped and sets overrun.
module word_out_buf #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_vld,
   input  logic [WIDTH-1:0] wr_dat,
   input  logic             wr_par_err,
   input  logic             bad_frame,
   input  logic             rdy,
   input  logic             ovr_clr,
   output logic [WIDTH-1:0] data,
   output logic             valid,
   output logic             par_err,
   output logic             frm_err,
   output logic             overrun
);

   logic hs;
   logic load;
   logic drop;

   assign hs   = valid & rdy;
   assign load = wr_vld & (~valid | hs);
   assign drop = wr_vld & valid & ~hs;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data    <= '0;
         valid   <= 1'b0;
         par_err <= 1'b0;
         frm_err <= 1'b0;
         overrun <= 1'b0;
      end else begin
         frm_err <= bad_frame;
         if (load) begin
            data    <= wr_dat;
            par_err <= wr_par_err;
            valid   <= 1'b1;
         end else if (hs) begin
            valid   <= 1'b0;
         end
         // A fresh overrun wins over a coincident clear.
         if (drop) begin
            overrun <= 1'b1;
         end else if (ovr_clr) begin
            overrun <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/serial_word_assembler.sv
// Deserialises start/data/parity/stop frames from a bit stream into parallel words.
// Latency: word is presented on the edge that samples the stop bit.
// Backpressure: one-word buffer; words arriving while it is full and unread are dropped (OVERRUN).
module serial_word_assembler
   import shift_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int PAR_EN = 1
) (
   input  logic             CLK,
   input  logic             RESET_N,
   input  logic             ENB,
   input  logic             S_IN,
   input  logic             DIR,
   input  logic             READY,
   input  logic             OVR_CLR,
   output logic [WIDTH-1:0] DATA,
   output logic             VALID,
   output logic             PAR_ERR,
   output logic             FRM_ERR,
   output logic             OVERRUN
);

   localparam int CNT_W = $clog2(WIDTH);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [WIDTH-1:0] sh, sh_nxt;
   logic             dir_q, dir_nxt;
   logic             perr_q, perr_nxt;
   logic             good_vld;
   logic             bad_evt;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         sh     <= '0;
         dir_q  <= 1'b0;
         perr_q <= 1'b0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         sh     <= sh_nxt;
         dir_q  <= dir_nxt;
         perr_q <= perr_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      sh_nxt    = sh;
      dir_nxt   = dir_q;
      perr_nxt  = perr_q;
      good_vld  = 1'b0;
      bad_evt   = 1'b0;
      if (ENB) begin
         case (state)
            ST_IDLE: begin
               if (S_IN == START_BIT) begin
                  dir_nxt   = DIR;
                  cnt_nxt   = '0;
                  perr_nxt  = 1'b0;
                  state_nxt = ST_DATA;
               end
            end
            ST_DATA: begin
               // LSB-first fills from the top so the first bit ends up in bit 0.
               sh_nxt = dir_q ? {sh[WIDTH-2:0], S_IN} : {S_IN, sh[WIDTH-1:1]};
               if (cnt == CNT_W'(WIDTH - 1)) begin
                  state_nxt = (PAR_EN != 0) ? ST_PARITY : ST_STOP;
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
            ST_PARITY: begin
               perr_nxt  = par_fail(16'(sh), S_IN);
               state_nxt = ST_STOP;
            end
            ST_STOP: begin
               state_nxt = ST_IDLE;
               if (S_IN == STOP_BIT) begin
                  good_vld = 1'b1;
               end else begin
                  bad_evt  = 1'b1;
               end
            end
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   word_out_buf #(
      .WIDTH(WIDTH)
   ) u_out_buf (
      .clk        (CLK),
      .rst_n      (RESET_N),
      .wr_vld     (good_vld),
      .wr_dat     (sh),
      .wr_par_err (perr_q),
      .bad_frame  (bad_evt),
      .rdy        (READY),
      .ovr_clr    (OVR_CLR),
      .data       (DATA),
      .valid      (VALID),
      .par_err    (PAR_ERR),
      .frm_err    (FRM_ERR),
      .overrun    (OVERRUN)
   );

endmodule

// File: tb/tb_serial_word_assembler.sv
// Self-checking bench: frame vector table, scoreboard on the handshake, reset corner case.
module tb_serial_word_assembler;
   import shift_pkg::*;

   localparam int W = 8;

   logic         CLK = 1'b0;
   logic         RESET_N;
   logic         ENB;
   logic         S_IN;
   logic         DIR;
   logic         READY;
   logic         OVR_CLR;
   logic [W-1:0] DATA;
   logic         VALID;
   logic         PAR_ERR;
   logic         FRM_ERR;
   logic         OVERRUN;

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct packed {
      logic [W-1:0] dat;
      logic         perr;
   } sb_t;
   sb_t  sb_q[$];
   logic mdl_valid;

   typedef struct {
      logic         dir;
      logic [W-1:0] w;
      logic         pinv;
      logic         stop;
      logic         rdy;
      logic         clr;
      logic         tog;
      logic [W-1:0] e_dat;
      logic         e_vld;
      logic         e_perr;
      logic         e_frm;
      logic         e_ovr;
      logic         drain;
      logic         clr_after;
   } vec_t;
   vec_t tbl[9];

   always #5 CLK = ~CLK;

   serial_word_assembler #(
      .WIDTH  (W),
      .PAR_EN (1)
   ) dut (
      .CLK     (CLK),
      .RESET_N (RESET_N),
      .ENB     (ENB),
      .S_IN    (S_IN),
      .DIR     (DIR),
      .READY   (READY),
      .OVR_CLR (OVR_CLR),
      .DATA    (DATA),
      .VALID   (VALID),
      .PAR_ERR (PAR_ERR),
      .FRM_ERR (FRM_ERR),
      .OVERRUN (OVERRUN)
   );

   task automatic chk1(input string name, input logic act, input logic exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Words leave the DUT only on a handshake; compare them against what was accepted.
   always @(negedge CLK) begin
      if (RESET_N === 1'b1 && VALID === 1'b1 && READY === 1'b1) begin
         if (sb_q.size() == 0) begin
            chk8("sb_nonempty", 8'(sb_q.size()), 8'd1);
         end else begin
            sb_t e;
            e = sb_q.pop_front();
            chk8("sb_data", DATA, e.dat);
            chk1("sb_perr", PAR_ERR, e.perr);
         end
      end
   end

   task automatic drive_bit(input logic b, input logic tog);
      S_IN = b;
      ENB  = 1'b1;
      @(posedge CLK); #1;
      if (tog) begin
         ENB  = 1'b0;
         S_IN = ~b;
         @(posedge CLK); #1;
      end
   endtask

   task automatic send_frame(input logic dir, input logic [W-1:0] w, input logic pinv,
                             input logic stop, input logic rdy, input logic clr,
                             input logic tog);
      DIR = dir;
      drive_bit(START_BIT, tog);
      DIR = ~dir;
      for (int i = 0; i < W; i++) begin
         drive_bit(dir ? w[W-1-i] : w[i], tog);
      end
      drive_bit((^w) ^ pinv, tog);
      READY   = rdy;
      OVR_CLR = clr;
      S_IN    = stop;
      ENB     = 1'b1;
      @(posedge CLK); #1;
      READY   = 1'b0;
      OVR_CLR = 1'b0;
      S_IN    = IDLE_LVL;
      if (stop == STOP_BIT && (!mdl_valid || rdy)) begin
         sb_q.push_back({w, pinv});
         mdl_valid = 1'b1;
      end
   endtask

   task automatic drain();
      READY = 1'b1;
      @(posedge CLK); #1;
      READY = 1'b0;
      mdl_valid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      //         dir   word   pinv  stop  rdy   clr   tog   e_dat  e_vld e_perr e_frm e_ovr drain clr_after
      tbl[0] = '{1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[1] = '{1'b0, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[2] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[3] = '{1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[4] = '{1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[5] = '{1'b0, 8'hC3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      tbl[6] = '{1'b1, 8'h07, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h07, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[7] = '{1'b0, 8'hF0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'hF0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[8] = '{1'b0, 8'h81, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h81, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

      mdl_valid = 1'b0;
      RESET_N   = 1'b0;
      ENB       = 1'b0;
      S_IN      = IDLE_LVL;
      DIR       = 1'b0;
      READY     = 1'b0;
      OVR_CLR   = 1'b0;
      #3;
      chk8("rst_data", DATA, 8'h00);
      chk1("rst_valid", VALID, 1'b0);
      chk1("rst_perr", PAR_ERR, 1'b0);
      chk1("rst_frm", FRM_ERR, 1'b0);
      chk1("rst_ovr", OVERRUN, 1'b0);
      @(posedge CLK); @(posedge CLK); #1;
      RESET_N = 1'b1;
      ENB     = 1'b1;
      @(posedge CLK); #1;

      for (int i = 0; i < 9; i++) begin
         send_frame(tbl[i].dir, tbl[i].w, tbl[i].pinv, tbl[i].stop, tbl[i].rdy,
                    tbl[i].clr, tbl[i].tog);
         chk8($sformatf("v%0d_data", i), DATA, tbl[i].e_dat);
         chk1($sformatf("v%0d_valid", i), VALID, tbl[i].e_vld);
         chk1($sformatf("v%0d_perr", i), PAR_ERR, tbl[i].e_perr);
         chk1($sformatf("v%0d_frm", i), FRM_ERR, tbl[i].e_frm);
         chk1($sformatf("v%0d_ovr", i), OVERRUN, tbl[i].e_ovr);
         @(posedge CLK); #1;
         chk1($sformatf("v%0d_frm_end", i), FRM_ERR, 1'b0);
         if (tbl[i].clr_after) begin
            OVR_CLR = 1'b1;
            @(posedge CLK); #1;
            OVR_CLR = 1'b0;
            chk1($sformatf("v%0d_ovr_clr", i), OVERRUN, 1'b0);
            chk8($sformatf("v%0d_clr_hold", i), DATA, tbl[i].e_dat);
            chk1($sformatf("v%0d_clr_valid", i), VALID, 1'b1);
         end
         if (tbl[i].drain) begin
            drain();
            chk1($sformatf("v%0d_drained", i), VALID, 1'b0);
         end
      end

      // Force an overrun so the reset has sticky state to clear.
      send_frame(1'b0, 8'h11, 1'b0, STOP_BIT, 1'b0, 1'b0, 1'b0);
      chk1("pre_rst_ovr", OVERRUN, 1'b1);

      // Abandon a frame after four data bits.
      DIR = 1'b0;
      drive_bit(START_BIT, 1'b0);
      for (int i = 0; i < 4; i++) drive_bit(1'b1, 1'b0);
      RESET_N = 1'b0;
      #2;
      chk8("midrst_data", DATA, 8'h00);
      chk1("midrst_valid", VALID, 1'b0);
      chk1("midrst_perr", PAR_ERR, 1'b0);
      chk1("midrst_frm", FRM_ERR, 1'b0);
      chk1("midrst_ovr", OVERRUN, 1'b0);
      sb_q.delete();
      mdl_valid = 1'b0;
      S_IN = IDLE_LVL;
      @(posedge CLK); #1;
      RESET_N = 1'b1;
      send_frame(1'b0, 8'h96, 1'b0, STOP_BIT, 1'b0, 1'b0, 1'b0);
      chk8("post_rst_data", DATA, 8'h96);
      chk1("post_rst_valid", VALID, 1'b1);
      chk1("post_rst_perr", PAR_ERR, 1'b0);
      chk1("post_rst_ovr", OVERRUN, 1'b0);
      drain();
      chk1("post_rst_drained", VALID, 1'b0);
      chk8("sb_empty", 8'(sb_q.size()), 8'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/serial_word_assembler.md
SERIAL_WORD_ASSEMBLER -- requirements
Module: serial_word_assembler

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the data bits per frame (legal range 2..16).
REQ-002 SHALL have parameter PAR_EN, default 1, meaning 1 = parity bit present and checked, 0 = no parity bit.
REQ-003 SHALL have port CLK, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port RESET_N, input, 1 bit, reset that is asynchronous and active-low.
REQ-005 SHALL have port ENB, input, 1 bit, bit-sample enable: S_IN is sampled only on edges where ENB=1.
REQ-006 SHALL have port S_IN, input, 1 bit, serial stream taken from the shift register's S_OUT.
REQ-007 SHALL have port DIR, input, 1 bit, bit order: 0 = LSB first, 1 = MSB first; sampled at the start bit and held for the frame.
REQ-008 SHALL have port READY, input, 1 bit, consumer accepts DATA when VALID=1 and READY=1.
REQ-009 SHALL have port OVR_CLR, input, 1 bit, synchronous clear of OVERRUN.
REQ-010 SHALL have port DATA, output, WIDTH bits, the assembled word.
REQ-011 SHALL have port VALID, output, 1 bit, DATA holds an unconsumed word.
REQ-012 SHALL have port PAR_ERR, output, 1 bit, parity status of the word in DATA; valid while VALID=1.
REQ-013 SHALL have port FRM_ERR, output, 1 bit, one-cycle pulse on a bad stop bit.
REQ-014 SHALL have port OVERRUN, output, 1 bit, sticky flag: a good frame was dropped.

Function
REQ-015 SHALL use this frame format: line idle 0, start bit 1, then WIDTH data bits, then an even-parity bit if PAR_EN=1, then stop bit 0.
REQ-016 SHALL implement FSM states IDLE, DATA, PARITY, STOP; PARITY is skipped when PAR_EN=0.
REQ-017 SHALL make all FSM transitions and samples occur only on edges with ENB=1; ENB=0 holds all state except the handshake and flags.
REQ-018 SHALL, in IDLE with S_IN=1, latch DIR, clear the bit counter and move to DATA; with S_IN=0 it stays in IDLE.
REQ-019 SHALL, in DATA, shift each sample in (DIR=0: into the MSB, shifting right; DIR=1: into the LSB, shifting left) and move on after WIDTH samples, using a counter of width $clog2(WIDTH).
REQ-020 SHALL, in PARITY, compute the even-parity result as XOR of the data bits and the parity bit; a nonzero result is a parity error.
REQ-021 SHALL, in STOP, treat S_IN=0 as a good frame and S_IN=1 as a frame error; both go to IDLE.
REQ-022 SHALL, on a good frame, load DATA and PAR_ERR and set VALID on the same edge that samples the stop bit (latency 0 cycles after the stop sample).
REQ-023 SHALL, on a frame error, discard the word, leave DATA/VALID unchanged and pulse FRM_ERR for one CLK cycle.
REQ-024 SHALL, when a handshake (VALID and READY) occurs with no new word, clear VALID on that edge.
REQ-025 SHALL, when a handshake and a good frame occur on the same edge, load the new word with VALID=1 and not set OVERRUN.
REQ-026 SHALL, when a good frame arrives while VALID=1 and READY=0, drop the new word, keep the old DATA and set OVERRUN.
REQ-027 SHALL hold OVERRUN until OVR_CLR=1; if OVR_CLR and a new overrun coincide, OVERRUN SHALL remain set.
REQ-028 SHALL ensure DATA and PAR_ERR do not change while VALID=1 and no handshake occurs.

Reset
REQ-029 SHALL, on RESET_N=0, immediately force FSM=IDLE, counter=0, DATA=0, VALID=0, PAR_ERR=0, FRM_ERR=0, OVERRUN=0, regardless of CLK.
REQ-030 SHALL, on reset mid-frame, abandon the partial word; the first ENB edge after release is treated as IDLE.

Structure
REQ-031 SHALL place the FSM state encoding and the frame-bit constants (START=1, STOP=0, IDLE_LVL=0) in the shared package shift_pkg.
REQ-032 SHALL implement the output register and handshake in one sub-module, word_out_buf; the FSM and shifter stay in the top level.

Verification
REQ-033 SHALL verify: WIDTH=8, PAR_EN=1, DIR=0, ENB=1, S_IN 1,[1,0,1,0,0,1,0,1],0,0 with READY=0 -> DATA=8'hA5, VALID=1, PAR_ERR=0.
REQ-034 SHALL verify: the same frame with the parity bit inverted -> DATA=8'hA5, VALID=1, PAR_ERR=1.
REQ-035 SHALL verify: DIR=1 and data sent as 1,0,1,0,0,1,0,1 -> DATA=8'hA5; stop bit 1 -> FRM_ERR pulses for 1 cycle and VALID stays 0.
REQ-036 SHALL verify: two good frames with READY=0 -> DATA holds the first word and OVERRUN=1; OVR_CLR=1 for one cycle -> OVERRUN=0.
REQ-037 SHALL verify: READY=1 on the stop-sample edge of the second frame while VALID=1 -> DATA is the second word, VALID=1, OVERRUN=0; ENB toggling 1/0 each cycle gives the same result.
REQ-038 SHALL verify: RESET_N pulsed low after 4 data bits -> all outputs 0 at once; a following full frame is received correctly.
